// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier (mult_seq).
package mult_pkg;

  localparam int WIDTH_DEFAULT = 32;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_abs.sv
// Combinational conditional two's complement negate: mag_o = sign_i ? -value_i : value_i.
module mult_abs #(
  parameter int W = 32
) (
  input  logic         sign_i,
  input  logic [W-1:0] value_i,
  output logic [W-1:0] mag_o
);

  // The most negative input maps to itself, which reads correctly as an unsigned magnitude.
  assign mag_o = sign_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier with start/busy/done handshake, WIDTH+1 cycle latency.
// Optional macro MULT_UNSIGNED_EN adds the is_unsigned port (multu); otherwise always signed.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
`ifdef MULT_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);

  mult_state_t state_q, state_d;

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               signed_mode;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_fix;

`ifdef MULT_UNSIGNED_EN
  assign signed_mode = ~is_unsigned;
`else
  assign signed_mode = 1'b1;
`endif

  mult_abs #(.W(WIDTH)) u_abs_a (
    .sign_i  (signed_mode & multiplicand[WIDTH-1]),
    .value_i (multiplicand),
    .mag_o   (a_mag)
  );

  mult_abs #(.W(WIDTH)) u_abs_b (
    .sign_i  (signed_mode & multiplier[WIDTH-1]),
    .value_i (multiplier),
    .mag_o   (b_mag)
  );

  mult_abs #(.W(2 * WIDTH)) u_abs_p (
    .sign_i  (neg_q),
    .value_i ({acc_q, mplier_q}),
    .mag_o   (prod_fix)
  );

  // NOTE: sequential state uses non-blocking assignments; reset here is synchronous.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A new start always wins over the RUN/FIX progression, discarding the current run.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: every signal gets a hold default before the case so no latch is inferred.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

    if (start) begin
      mcand_d  = a_mag;
      mplier_d = b_mag;
      neg_d    = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          // Shift {carry, acc, multiplier} right; low product bits fill in from the top.
          acc_d    = sum[WIDTH:1];
          mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
          cnt_d    = cnt_q + CW'(1);
        end
        FIX: begin
          {hi_d, lo_d} = prod_fix;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq; define MULT_UNSIGNED_EN to also exercise multu.
module tb_mult_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
`ifdef MULT_UNSIGNED_EN
  logic         is_unsigned;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  mult_seq #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef MULT_UNSIGNED_EN
    .is_unsigned  (is_unsigned),
`endif
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  // Drive a one-cycle start at a negedge; operands are scrambled afterwards.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
`ifdef MULT_UNSIGNED_EN
    is_unsigned  = uns;
`endif
    @(negedge clock);
    start        = 1'b0;
    multiplicand = 32'hA5A5_5A5A;
    multiplier   = 32'h5A5A_A5A5;
`ifdef MULT_UNSIGNED_EN
    is_unsigned  = ~uns;
`endif
  endtask

  // Count busy cycles until done is seen, bounded to 100 cycles.
  task automatic wait_done(output int busy_cyc, output bit seen);
    busy_cyc = 0;
    seen     = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cyc++;
      @(negedge clock);
    end
  endtask

  task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic uns, input logic [W-1:0] exp_hi,
                               input logic [W-1:0] exp_lo);
    int busy_cyc;
    bit seen;
    start_op(a, b, uns);
    wait_done(busy_cyc, seen);
    vectors++;
    if (!seen || busy_cyc !== 33) begin
      miscompares++;
      $display("FAIL %s latency: done_seen=%0d busy_cycles=%0d, required done_seen=1 busy_cycles=33",
               name, seen, busy_cyc);
    end
    vectors++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      miscompares++;
      $display("FAIL %s product: got hi=%h lo=%h, required hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
    end
    last_hi = exp_hi;
    last_lo = exp_lo;
    @(negedge clock);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_pulse_width: done=%b one cycle later, required 0", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    // start together with reset must be ignored
    start        = 1'b1;
    multiplicand = 32'd3;
    multiplier   = 32'd5;
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_beats_start: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_signed();
    run_and_check("3x5",        32'd3,         32'd5,         1'b0, 32'h0000_0000, 32'h0000_000F);
    run_and_check("m3x5",       32'hFFFF_FFFD, 32'd5,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_and_check("minxmin",    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000);
    run_and_check("minxm1",     32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000);
    run_and_check("m1xm1_sgn",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0001);
  endtask

  task automatic test_unsigned();
`ifdef MULT_UNSIGNED_EN
    run_and_check("m1xm1_uns",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    run_and_check("minxmin_uns", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
    run_and_check("m1xm1_sgn2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0001);
`endif
  endtask

  task automatic test_restart();
    int busy_cyc;
    bit seen;
    int extra_done;
    start_op(32'd7, 32'd9, 1'b0);
    repeat (9) @(negedge clock);
    start_op(32'd2, 32'hFFFF_FFFC, 1'b0);
    vectors++;
    if (hi !== last_hi || lo !== last_lo) begin
      miscompares++;
      $display("FAIL restart_hold: got hi=%h lo=%h during run, required hi=%h lo=%h",
               hi, lo, last_hi, last_lo);
    end
    wait_done(busy_cyc, seen);
    vectors++;
    if (!seen || busy_cyc !== 33) begin
      miscompares++;
      $display("FAIL restart_latency: done_seen=%0d busy_cycles=%0d, required done_seen=1 busy_cycles=33",
               seen, busy_cyc);
    end
    vectors++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF8) begin
      miscompares++;
      $display("FAIL restart_product: got hi=%h lo=%h, required hi=ffffffff lo=fffffff8", hi, lo);
    end
    extra_done = 0;
    repeat (10) begin
      @(negedge clock);
      if (done === 1'b1) extra_done++;
    end
    vectors++;
    if (extra_done !== 0) begin
      miscompares++;
      $display("FAIL restart_single_done: extra done pulses=%0d, required 0", extra_done);
    end
  endtask

  task automatic test_abort();
    int done_cnt;
    start_op(32'd7, 32'd9, 1'b0);
    repeat (19) @(negedge clock);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_busy_before: busy=%b, required 1", busy);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      miscompares++;
      $display("FAIL abort_state: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", busy, hi, lo);
    end
    done_cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) done_cnt++;
    end
    vectors++;
    if (done_cnt !== 0 || hi !== '0 || lo !== '0) begin
      miscompares++;
      $display("FAIL abort_no_done: done pulses=%0d hi=%h lo=%h, required 0 pulses hi=0 lo=0",
               done_cnt, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cyc;
    bit seen;
    start_op(32'd0, 32'hFFFF_FFFF, 1'b0);
    wait_done(busy_cyc, seen);
    vectors++;
    if (!seen || hi !== '0 || lo !== '0) begin
      miscompares++;
      $display("FAIL zero_x_m1: done_seen=%0d hi=%h lo=%h, required done_seen=1 hi=0 lo=0", seen, hi, lo);
    end
    // start issued during the done cycle
    start_op(32'd6, 32'hFFFF_FFF9, 1'b0);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_busy: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    wait_done(busy_cyc, seen);
    vectors++;
    if (!seen || busy_cyc !== 33 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFD6) begin
      miscompares++;
      $display("FAIL b2b_product: done_seen=%0d busy_cycles=%0d hi=%h lo=%h, required 1 33 ffffffff ffffffd6",
               seen, busy_cyc, hi, lo);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
`ifdef MULT_UNSIGNED_EN
    is_unsigned  = 1'b0;
`endif
    @(negedge clock);
    test_reset();
    test_signed();
    test_unsigned();
    test_restart();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
